// File: rtl/prbs_checker.sv
// Serial PRBS checker for a Fibonacci LFSR stream (x^ORDER + x^TAP + 1).
// It seeds from the received bits, verifies them, locks, then runs as a flywheel and counts errors.
module prbs_checker #(
  parameter int ORDER       = 7,
  parameter int TAP         = 6,
  parameter int LOCK_COUNT  = 16,
  parameter int WINDOW      = 64,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int FW = $clog2(ORDER + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {SEED, VERIFY, LOCK} state_t;

  state_t           state;
  logic [ORDER-1:0] s;
  logic [FW-1:0]    fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic [WW-1:0]    win_cnt;
  logic [EW-1:0]    win_errs;
  logic             expb, mis;

  assign expb = s[ORDER-1] ^ s[TAP-1];
  assign mis  = in_bit ^ expb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEED;
      s         <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        unique case (state)
          SEED: begin
            s <= {s[ORDER-2:0], in_bit};
            if (fill_cnt == FW'(ORDER - 1)) begin
              state     <= VERIFY;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + FW'(1);
            end
          end
          VERIFY: begin
            s <= {s[ORDER-2:0], in_bit};
            if (mis) begin
              state    <= SEED;
              fill_cnt <= '0;
            end else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state    <= LOCK;
              locked   <= 1'b1;
              win_cnt  <= '0;
              win_errs <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end
          LOCK: begin
            // Flywheel: the register regenerates its own prediction, so line errors never reach it.
            s <= {s[ORDER-2:0], expb};
            if (bit_count != CMAX) bit_count <= bit_count + CNT_W'(1);
            if (mis) begin
              err_pulse <= 1'b1;
              if (err_count != CMAX) err_count <= err_count + CNT_W'(1);
            end
            if (mis && win_errs == EW'(UNLOCK_ERRS - 1)) begin
              state    <= SEED;
              locked   <= 1'b0;
              fill_cnt <= '0;
            end else if (win_cnt == WW'(WINDOW - 1)) begin
              win_cnt  <= '0;
              win_errs <= '0;
            end else begin
              win_cnt <= win_cnt + WW'(1);
              if (mis) win_errs <= win_errs + EW'(1);
            end
          end
          default: state <= SEED;
        endcase
      end
      // Placed last so a same-edge clear overrides any increment above.
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomized and directed bench for prbs_checker, checked every cycle against a queue-based model.
// Two instances (CNT_W 16 and 4) share stimulus so saturation is observed alongside wide counts.
module tb_prbs_checker;
  localparam int ORDER = 7, TAP = 6, LOCK_COUNT = 16, WINDOW = 64, UNLOCK_ERRS = 4;

  logic clk, rst_n, in_valid, in_bit, clear;
  logic locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count, bit_count;
  logic [3:0]  err_count4, bit_count4;

  prbs_checker #(.ORDER(ORDER), .TAP(TAP), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
                 .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .bit_count(bit_count));

  prbs_checker #(.ORDER(ORDER), .TAP(TAP), .LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW),
                 .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clear(clear),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .bit_count(bit_count4));

  initial begin clk = 0; forever #5 clk = ~clk; end

  int n_chk = 0, n_fail = 0;
  bit run = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mode;            // 0 seeding, 1 verifying, 2 locked
  bit hist[$];         // hist[k] = bit received/predicted k+1 positions ago
  int fill, match, wcnt, werrs;
  int m_locked, m_pulse, ec16, bc16, ec4, bc4;

  function automatic int satinc(input int v, input int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    mode = 0; hist = {};
    for (int i = 0; i < ORDER; i++) hist.push_back(1'b0);
    fill = 0; match = 0; wcnt = 0; werrs = 0;
    m_locked = 0; m_pulse = 0; ec16 = 0; bc16 = 0; ec4 = 0; bc4 = 0;
  endtask

  task automatic push(input bit x);
    hist.push_front(x);
    void'(hist.pop_back());
  endtask

  task automatic model_update(input bit v, input bit b, input bit c);
    bit e, mis;
    m_pulse = 0;
    if (v) begin
      e = hist[ORDER-1] ^ hist[TAP-1];
      mis = (b != e);
      if (mode == 0) begin
        push(b); fill++;
        if (fill == ORDER) begin mode = 1; match = 0; end
      end else if (mode == 1) begin
        push(b);
        if (mis) begin mode = 0; fill = 0; end
        else begin
          match++;
          if (match == LOCK_COUNT) begin mode = 2; m_locked = 1; wcnt = 0; werrs = 0; end
        end
      end else begin
        push(e);
        bc16 = satinc(bc16, 65535); bc4 = satinc(bc4, 15);
        wcnt++;
        if (mis) begin
          m_pulse = 1; werrs++;
          ec16 = satinc(ec16, 65535); ec4 = satinc(ec4, 15);
        end
        if (werrs == UNLOCK_ERRS) begin mode = 0; m_locked = 0; fill = 0; end
        else if (wcnt == WINDOW) begin wcnt = 0; werrs = 0; end
      end
    end
    if (c) begin ec16 = 0; bc16 = 0; ec4 = 0; bc4 = 0; end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("locked", int'(locked), m_locked);
      chk("err_pulse", int'(err_pulse), m_pulse);
      chk("err_count", int'(err_count), ec16);
      chk("bit_count", int'(bit_count), bc16);
      chk("locked4", int'(locked4), m_locked);
      chk("err_pulse4", int'(err_pulse4), m_pulse);
      chk("err_count4", int'(err_count4), ec4);
      chk("bit_count4", int'(bit_count4), bc4);
    end
  end

  // ---------------- stimulus ----------------
  logic [6:0] g;
  function automatic bit gen_next();
    bit nb;
    nb = g[6] ^ g[5];
    g = {g[5:0], nb};
    return nb;
  endfunction

  task automatic step(input bit v, input bit b, input bit c);
    in_valid = v; in_bit = b; clear = c;
    @(posedge clk);
    model_update(v, b, c);
    @(negedge clk);
  endtask

  task automatic send(input bit err, input bit c = 1'b0);
    bit b;
    b = gen_next() ^ err;
    step(1'b1, b, c);
  endtask

  task automatic do_reset();
    in_valid = 0; in_bit = 0; clear = 0;
    rst_n = 0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1;
    g = 7'h7F;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_bit = 0; clear = 0; g = 7'h7F;
    model_reset();
    #12;
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_bit_count", int'(bit_count), 0);
    @(negedge clk);
    rst_n = 1; run = 1;

    // Continuous stream: lock on the 23rd bit, then 100 counted bits.
    repeat (22) send(0);
    chk("lock_before_23", int'(locked), 0);
    send(0);
    chk("lock_at_23", int'(locked), 1);
    chk("model_lock_at_23", m_locked, 1);
    repeat (100) send(0);
    chk("bits_100", int'(bit_count), 100);
    chk("errs_0", int'(err_count), 0);

    // Single error: one pulse, flywheel keeps the next 50 bits clean.
    send(1);
    chk("single_pulse", int'(err_pulse), 1);
    chk("single_count", int'(err_count), 1);
    chk("single_locked", int'(locked), 1);
    send(0);
    chk("single_pulse_drop", int'(err_pulse), 0);
    repeat (50) send(0);
    chk("flywheel_count", int'(err_count), 1);
    send(0, 1'b1);
    chk("clear_errs", int'(err_count), 0);
    chk("clear_bits", int'(bit_count), 0);

    // Four errors within 20 bits: unlock on the 4th, then relock after 23.
    for (int i = 0; i < 16; i++) begin
      send(i % 5 == 0);
      if (i == 10) chk("still_locked_3", int'(locked), 1);
    end
    chk("unlock_4th", int'(locked), 0);
    chk("unlock_count", int'(err_count), 4);
    chk("unlock_pulse", int'(err_pulse), 1);
    repeat (22) send(0);
    chk("relock_before", int'(locked), 0);
    send(0);
    chk("relock", int'(locked), 1);
    chk("relock_count", int'(err_count), 4);

    // Three errors in one window, one in the next: no unlock.
    for (int k = 0; k < 80; k++) send(k == 10 || k == 20 || k == 30 || k == 70);
    chk("window_split_locked", int'(locked), 1);
    chk("window_split_count", int'(err_count), 8);

    // Isolated errors saturate the narrow counter.
    send(0, 1'b1);
    for (int i = 0; i < 20; i++) begin send(1); repeat (24) send(0); end
    chk("sat4", int'(err_count4), 15);
    chk("nosat16", int'(err_count), 20);
    chk("sat_locked", int'(locked), 1);
    send(1, 1'b1);
    chk("clear_wins", int'(err_count), 0);
    chk("clear_wins4", int'(err_count4), 0);
    chk("clear_pulse", int'(err_pulse), 1);

    // Random valid gaps, errors and clears.
    for (int i = 0; i < 3000; i++) begin
      bit v, err, c;
      v = ($urandom % 4) != 0;
      err = ($urandom % 40) == 0;
      c = ($urandom % 200) == 0;
      if (v) send(err, c);
      else step(1'b0, 1'(($urandom)), c);
    end

    // Reset while locked aborts immediately.
    do_reset();
    repeat (23) send(0);
    chk("pre_reset_locked", int'(locked), 1);
    rst_n = 0;
    #1;
    chk("async_locked", int'(locked), 0);
    chk("async_pulse", int'(err_pulse), 0);
    chk("async_errs", int'(err_count), 0);
    chk("async_bits", int'(bit_count), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1; g = 7'h7F;
    repeat (22) send(0);
    chk("fresh_lock_before", int'(locked), 0);
    send(0);
    chk("fresh_lock", int'(locked), 1);

    // Every other cycle idle: still 23 accepted bits.
    do_reset();
    for (int i = 1; i <= 23; i++) begin
      step(1'b0, 1'(($urandom)), 1'b0);
      send(0);
      if (i == 22) chk("gap_lock_before", int'(locked), 0);
    end
    chk("gap_lock", int'(locked), 1);

    // Mismatch at bit 15 reseeds: lock at bit 38.
    do_reset();
    for (int i = 1; i <= 38; i++) begin
      send(i == 15);
      if (i == 15) chk("verify_no_pulse", int'(err_pulse), 0);
      if (i == 23) chk("verify_no_lock23", int'(locked), 0);
      if (i == 37) chk("verify_lock_before", int'(locked), 0);
    end
    chk("verify_lock38", int'(locked), 1);
    chk("verify_errs", int'(err_count), 0);

    run = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial PRBS receive-side checker: the consuming end of an XOR-feedback (Fibonacci LFSR) pattern generator. It self-synchronises to an incoming bit stream, asserts lock once the stream matches the polynomial, then flags and counts bit errors. It sits after a DUT or loopback path in the gate-level test harnesses, so XOR-based datapaths can be checked in hardware rather than only by waveform inspection.

## Interface
- ORDER, 7: LFSR length; polynomial x^ORDER + x^TAP + 1.
- TAP, 6: feedback tap, 1 <= TAP < ORDER.
- LOCK_COUNT, 16: consecutive matching bits required in VERIFY before lock.
- WINDOW, 64: bit window for loss-of-lock evaluation.
- UNLOCK_ERRS, 4: errors within one window that force loss of lock.
- CNT_W, 16: width of err_count and bit_count.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_bit is sampled on this edge.
- in_bit  input  1  received serial bit.
- clear  input  1  synchronous clear of err_count and bit_count.
- locked  output  1  checker is synchronised.
- err_pulse  output  1  one-cycle strobe: the last accepted bit mismatched while locked.
- err_count  output  CNT_W  saturating count of errors while locked.
- bit_count  output  CNT_W  saturating count of bits checked while locked.

## Operation
- Shift register s[ORDER-1:0], where s[0] is the newest bit. Expected bit e = s[ORDER-1] ^ s[TAP-1]. Mismatch = in_bit != e.
- Nothing changes on edges where in_valid = 0. err_pulse is 0 in the following cycle.
- SEED: each accepted bit shifts s <= {s[ORDER-2:0], in_bit} and increments fill_cnt. On the ORDER-th bit, go to VERIFY and clear match_cnt.
- VERIFY: each accepted bit shifts in in_bit.
  - Match: increment match_cnt. On the LOCK_COUNT-th consecutive match, go to LOCKED and set locked. Clear win_cnt and win_errs.
  - Mismatch: go to SEED with fill_cnt = 0. No error is counted.
- LOCKED (flywheel): s <= {s[ORDER-2:0], e}. Received bits never corrupt s.
  - Each accepted bit increments bit_count and win_cnt.
  - Mismatch: err_pulse = 1 for the next cycle, and err_count and win_errs increment.
  - When win_errs reaches UNLOCK_ERRS, go to SEED: locked = 0, fill_cnt = 0. err_pulse and err_count still reflect that bit.
  - When win_cnt completes WINDOW bits, win_cnt and win_errs return to 0 after including the current bit. If the same bit also hits UNLOCK_ERRS, unlock wins.
- err_count and bit_count saturate at 2^CNT_W - 1 and never wrap.
- clear zeroes err_count and bit_count. It wins over a same-edge increment. err_pulse, state and lock are unaffected.
- All-zero seed: an all-zero s in SEED/VERIFY predicts 0 forever. The checker still locks on an all-zero stream; this is by design and is documented, not detected.

## Timing
- All outputs are registered.
- Reset (rst_n low, asynchronous): state = SEED, s = 0, all counters = 0, locked = 0, err_pulse = 0, err_count = 0, bit_count = 0. Reset during any state aborts immediately. No partial lock is retained.
- Lock latency: locked rises at the edge sampling the (ORDER + LOCK_COUNT)-th consecutive good accepted bit. This is 23 accepted bits for the defaults.
- err_pulse is high for exactly one cycle, after the edge that sampled the erroneous bit. Two back-to-back erroneous accepted bits give two consecutive high cycles.
- The lock-decision bit is not counted in bit_count. The first counted bit is the next accepted bit.
- The unlock transition and the final error's count and pulse occur on the same edge.

## Test plan
- Reset, then a continuous PRBS7 stream (seed 7'h7F, in_valid = 1) -> locked rises after the 23rd bit; err_count = 0; bit_count = 100 after 100 further bits.
- Same stream with in_valid deasserted every other cycle -> lock after 23 accepted bits (about 46 cycles); err_pulse never asserts.
- After lock, invert one bit -> err_pulse high for 1 cycle; err_count = 1; locked stays 1; no follow-on errors on the next 50 bits (flywheel).
- After lock, invert 4 bits within 20 bits -> locked drops on the 4th error edge with err_count = 4. Clean stream resumes -> relock after 23 bits; err_count stays 4.
- 3 errors in one window followed by 1 error in the next window -> no unlock. With CNT_W = 4, 20 such isolated errors -> err_count saturates at 15. Pulse clear together with an error -> err_count = 0.
- Single mismatch at bit 15 (inside VERIFY) -> return to SEED; lock at bit 15 + 23 = 38. Then assert rst_n low while locked -> all outputs 0 immediately; relock takes a fresh 23 bits.
